// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces a pushbutton, producing a clean level
// plus one-cycle press, release and long-press pulses.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic KEY_IN,
    output logic KEY_LEVEL,
    output logic KEY_PRESS,
    output logic KEY_RELEASE,
    output logic KEY_LONG
);
    localparam int MAX_CNT = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ? DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
    localparam int CW = $clog2(MAX_CNT + 1);
    localparam logic [1:0] RELEASED     = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_PRESS_CYCLES);

    logic          s1_q, s2_q, ks;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, press_q, release_q, long_q, long_done_q, fire;

    assign ks = s2_q;
    // long_done_q keeps a release-glitch restart from firing a second long pulse
    assign fire = (state_q == PRESSED) && ks && (cnt_q == LONG_MAX - ONE) && !long_done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                state_d = ks ? PRESS_WAIT : RELEASED;
                cnt_d   = ks ? ONE : '0;
            end
            PRESS_WAIT: begin
                state_d = !ks ? RELEASED : (cnt_q == DEB_LAST) ? PRESSED : PRESS_WAIT;
                cnt_d   = (!ks || cnt_q == DEB_LAST) ? '0 : cnt_q + ONE;
            end
            PRESSED: begin
                state_d = ks ? PRESSED : RELEASE_WAIT;
                cnt_d   = !ks ? ONE : (cnt_q == LONG_MAX) ? cnt_q : cnt_q + ONE;
            end
            RELEASE_WAIT: begin
                state_d = ks ? PRESSED : (cnt_q == DEB_LAST) ? RELEASED : RELEASE_WAIT;
                cnt_d   = (ks || cnt_q == DEB_LAST) ? '0 : cnt_q + ONE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            state_q     <= RELEASED;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            long_done_q <= 1'b0;
        end else begin
            s1_q        <= ACTIVE_LOW ? ~KEY_IN : KEY_IN;
            s2_q        <= s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            level_q     <= state_d[1];
            press_q     <= (state_q == PRESS_WAIT) && (state_d == PRESSED);
            release_q   <= (state_q == RELEASE_WAIT) && (state_d == RELEASED);
            long_q      <= fire;
            long_done_q <= (state_q == RELEASED) ? 1'b0 : (long_done_q | fire);
        end
    end

    assign KEY_LEVEL   = level_q;
    assign KEY_PRESS   = press_q;
    assign KEY_RELEASE = release_q;
    assign KEY_LONG    = long_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed stimulus with a pulse scoreboard for key_debounce
// (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, active-low key).
module tb_key_debounce;
    logic CLK = 1'b0;
    logic RSTn, KEY_IN;
    logic KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_LONG;

    typedef struct {
        logic [1:0] kind;
        int         cyc;
    } ev_t;

    localparam logic [1:0] K_PRESS = 2'd1, K_RELEASE = 2'd2, K_LONG = 2'd3;

    ev_t  q[$];
    int   cyc = 0;
    int   vecs = 0;
    int   errs = 0;
    logic prev_level = 1'b0;

    key_debounce #(
        .DEBOUNCE_CYCLES(4),
        .LONG_PRESS_CYCLES(10),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .KEY_IN(KEY_IN),
        .KEY_LEVEL(KEY_LEVEL),
        .KEY_PRESS(KEY_PRESS),
        .KEY_RELEASE(KEY_RELEASE),
        .KEY_LONG(KEY_LONG)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        q.push_back(e);
    endtask

    task automatic drive(input logic v, input int n);
        KEY_IN = v;
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: every pulse must match the oldest expected event in kind and cycle
    always @(negedge CLK) begin
        logic [1:0] kind;
        ev_t        e;
        if (RSTn === 1'b1) begin
            if (KEY_PRESS || KEY_RELEASE || KEY_LONG) begin
                kind = KEY_PRESS ? K_PRESS : KEY_RELEASE ? K_RELEASE : K_LONG;
                vecs++;
                if ($countones({KEY_PRESS, KEY_RELEASE, KEY_LONG}) != 1) begin
                    errs++;
                    $display("FAIL exclusive: got press=%b release=%b long=%b, expected one pulse", KEY_PRESS, KEY_RELEASE, KEY_LONG);
                end
                vecs++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", kind, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.kind !== kind || e.cyc != cyc) begin
                        errs++;
                        $display("FAIL pulse: got kind %0d at cycle %0d, expected kind %0d at cycle %0d", kind, cyc, e.kind, e.cyc);
                    end
                end
                if (KEY_PRESS) chk("level_on_press", KEY_LEVEL, 1'b1);
                if (KEY_RELEASE) chk("level_on_release", KEY_LEVEL, 1'b0);
            end else begin
                chk("level_steady", KEY_LEVEL, prev_level);
            end
        end
        prev_level = KEY_LEVEL;
    end

    initial begin
        int k;
        RSTn   = 1'b0;
        KEY_IN = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_level", KEY_LEVEL, 1'b0);
        chk("rst_press", KEY_PRESS, 1'b0);
        chk("rst_release", KEY_RELEASE, 1'b0);
        chk("rst_long", KEY_LONG, 1'b0);
        RSTn = 1'b1;
        drive(1'b1, 3);
        // clean press held long enough for one long pulse, then clean release
        k = cyc + 1;
        expect_ev(K_PRESS, k + 5);
        expect_ev(K_LONG, k + 15);
        drive(1'b0, 25);
        k = cyc + 1;
        expect_ev(K_RELEASE, k + 5);
        drive(1'b1, 10);
        // press bounce: 3 low, 1 high, then held low
        drive(1'b0, 3);
        drive(1'b1, 1);
        k = cyc + 1;
        expect_ev(K_PRESS, k + 5);
        drive(1'b0, 8);
        // release glitch of 2 cycles is absorbed, then clean release
        drive(1'b1, 2);
        drive(1'b0, 8);
        k = cyc + 1;
        expect_ev(K_RELEASE, k + 5);
        drive(1'b1, 8);
        // back-to-back press / release / press
        k = cyc + 1;
        expect_ev(K_PRESS, k + 5);
        drive(1'b0, 6);
        k = cyc + 1;
        expect_ev(K_RELEASE, k + 5);
        drive(1'b1, 6);
        k = cyc + 1;
        expect_ev(K_PRESS, k + 5);
        drive(1'b0, 8);
        // asynchronous reset while pressed, key still held afterwards
        #2;
        chk("pre_rst_level", KEY_LEVEL, 1'b1);
        RSTn = 1'b0;
        #1;
        chk("mid_rst_level", KEY_LEVEL, 1'b0);
        chk("mid_rst_press", KEY_PRESS, 1'b0);
        chk("mid_rst_release", KEY_RELEASE, 1'b0);
        chk("mid_rst_long", KEY_LONG, 1'b0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        k = cyc + 1;
        expect_ev(K_PRESS, k + 5);
        expect_ev(K_LONG, k + 15);
        drive(1'b0, 20);
        k = cyc + 1;
        expect_ev(K_RELEASE, k + 5);
        drive(1'b1, 10);
        while (q.size() > 0) begin
            ev_t e;
            e = q.pop_front();
            vecs++;
            errs++;
            $display("FAIL missing_pulse: got nothing, expected kind %0d at cycle %0d", e.kind, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable samples needed to accept a level change (20 ms at 50 MHz); legal range is 2 or more.
REQ-002 The block SHALL have parameter LONG_PRESS_CYCLES, default 50000000, meaning the number of cycles spent in PRESSED before KEY_LONG fires; legal range is 1 or more.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1, meaning that KEY_IN = 0 denotes "pressed" (when 0, KEY_IN = 1 denotes "pressed").
REQ-004 The block SHALL have port CLK, input, 1 bit: the system clock, 50 MHz; all state updates occur on the rising edge.
REQ-005 The block SHALL have port RSTn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port KEY_IN, input, 1 bit: the raw, asynchronous, bouncing pushbutton.
REQ-007 The block SHALL have port KEY_LEVEL, output, 1 bit: the debounced key state, 1 = pressed; it drives the SP input of the downstream single-pulse stage.
REQ-008 The block SHALL have port KEY_PRESS, output, 1 bit: a one-cycle pulse on an accepted press.
REQ-009 The block SHALL have port KEY_RELEASE, output, 1 bit: a one-cycle pulse on an accepted release.
REQ-010 The block SHALL have port KEY_LONG, output, 1 bit: a one-cycle pulse when a press has been held for LONG_PRESS_CYCLES.

Function
REQ-011 KEY_IN SHALL pass through a two-flop synchronizer; the polarity-normalized output ks is 1 = pressed.
REQ-012 The FSM SHALL have four states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; all transitions are evaluated on the rising edge of CLK using ks.
REQ-013 In RELEASED: if ks = 1, the FSM SHALL go to PRESS_WAIT with cnt = 1; otherwise it stays, with cnt = 0.
REQ-014 In PRESS_WAIT: if ks = 1 and cnt = DEBOUNCE_CYCLES-1, the FSM SHALL go to PRESSED with cnt = 0; if ks = 1 otherwise, cnt increments; if ks = 0, the FSM returns to RELEASED with cnt = 0 and emits no pulse.
REQ-015 In PRESSED: if ks = 0, the FSM SHALL go to RELEASE_WAIT with cnt = 1; otherwise cnt increments and saturates at LONG_PRESS_CYCLES.
REQ-016 In RELEASE_WAIT: if ks = 0 and cnt = DEBOUNCE_CYCLES-1, the FSM SHALL go to RELEASED; if ks = 0 otherwise, cnt increments; if ks = 1, the FSM returns to PRESSED with the long-press count cleared to 0 and emits no pulse.
REQ-017 KEY_LEVEL SHALL be registered, equal to 1 in PRESSED and RELEASE_WAIT, and 0 otherwise.
REQ-018 Press latency SHALL be as follows: if KEY_IN is first captured as pressed at edge k and held, KEY_LEVEL rises after edge k+DEBOUNCE_CYCLES+1; release latency is identical.
REQ-019 KEY_PRESS SHALL be high for exactly the one cycle in which KEY_LEVEL first reads 1; KEY_RELEASE SHALL be high for exactly the one cycle in which KEY_LEVEL first reads 0.
REQ-020 KEY_LONG SHALL pulse for one cycle when cnt in PRESSED reaches LONG_PRESS_CYCLES, at most once per accepted press, and SHALL never repeat while the key is held.
REQ-021 A bounce in RELEASE_WAIT that returns to PRESSED SHALL restart the long-press count and SHALL NOT produce KEY_PRESS.
REQ-022 The counter width SHALL be clog2(max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)+1) bits and SHALL never wrap.
REQ-023 KEY_PRESS, KEY_RELEASE and KEY_LONG SHALL be mutually exclusive in any cycle.

Reset
REQ-024 While RSTn = 0, both synchronizer flops SHALL hold the released level, the state SHALL be RELEASED, cnt SHALL be 0, and KEY_LEVEL, KEY_PRESS, KEY_RELEASE and KEY_LONG SHALL all be 0.
REQ-025 Reset asserted mid-operation SHALL force all outputs to 0 immediately and asynchronously, with no KEY_RELEASE pulse.
REQ-026 If the key is held through reset deassertion, the block SHALL follow the normal press path: KEY_PRESS occurs DEBOUNCE_CYCLES+1 edges after the first post-reset capture.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ACTIVE_LOW=1)
REQ-027 Clean press: KEY_IN 1->0 captured at edge k and held -> KEY_LEVEL = 1 and KEY_PRESS = 1 after edge k+5, and KEY_PRESS = 0 after edge k+6.
REQ-028 Bounce: KEY_IN low for 3 cycles, high for 1 cycle, then held low -> no pulse during the bounce, and KEY_PRESS fires exactly once, 5 edges after the final low capture.
REQ-029 Long press: key held for 20 cycles after acceptance -> a single KEY_LONG pulse 10 cycles after KEY_PRESS, and KEY_LONG stays 0 for the remainder of the hold.
REQ-030 Release glitch: in PRESSED, KEY_IN high for 2 cycles then low again -> KEY_LEVEL stays 1 and no KEY_RELEASE occurs; a later clean release gives KEY_RELEASE 5 edges after capture.
REQ-031 Reset mid-press: RSTn = 0 while KEY_LEVEL = 1 -> all outputs 0 immediately; after reset deasserts with the key still held, KEY_PRESS fires 5 edges after the first capture.
REQ-032 Back-to-back: press, release, press, each held for 6 cycles -> the output sequence is KEY_PRESS, KEY_RELEASE, KEY_PRESS, with no KEY_LONG.
